fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the multicycle controller.
- Owns the PC. Reads one- or two-word instructions from a variable-latency memory over a req/ack handshake, then holds IR and TR with a valid flag until the controller takes them.
- Accepts jump redirects from the controller.
- Presents IR[7:4] as the controller's 4-bit instruction input.

---
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads one- or two-word instructions over a
// req/ack memory handshake and holds them in IR/TR until the controller takes them.
module fetch_unit #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              instr_valid_o,
  output logic [3:0]        instruction_o,
  output logic [DATA_W-1:0] ir_o,
  output logic [DATA_W-1:0] tr_o,
  input  logic              instr_take_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic [ADDR_W-1:0] pc_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH1 = 2'd1,
    FETCH2 = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] tr_q, tr_d;
  logic              discard_q, discard_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      tr_q      <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      tr_q      <= tr_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    tr_d      = tr_q;
    discard_d = discard_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH1;
        if (jump_en_i) pc_d = jump_addr_i;
      end
      FETCH1, FETCH2: begin
        // A redirect before the ack leaves a read in flight whose data must be dropped.
        if (jump_en_i) begin
          pc_d = jump_addr_i;
          if (mem_ack_i) begin
            discard_d = 1'b0;
            state_d   = FETCH1;
          end else begin
            discard_d = 1'b1;
          end
        end else if (mem_ack_i) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = FETCH1;
          end else begin
            pc_d = pc_q + PC_ONE;
            if (state_q == FETCH1) begin
              ir_d = mem_rdata_i;
              if (mem_rdata_i[7:6] == 2'b11) begin
                state_d = FETCH2;
              end else begin
                tr_d    = '0;
                state_d = HOLD;
              end
            end else begin
              tr_d    = mem_rdata_i;
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (jump_en_i) begin
          pc_d    = jump_addr_i;
          state_d = FETCH1;
        end else if (instr_take_i) begin
          state_d = FETCH1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_o     = (state_q == FETCH1) || (state_q == FETCH2);
  assign instr_valid_o = (state_q == HOLD);
  assign mem_addr_o    = pc_q;
  assign pc_o          = pc_q;
  assign ir_o          = ir_q;
  assign tr_o          = tr_q;
  assign instruction_o = ir_q[7:4];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a variable-latency memory model feeds the DUT and
// expected IR/TR/PC triples are queued as stimulus is set up, then popped on instr_valid.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memReq, memAck, instrValid, instrTake, jumpEn;
  logic [11:0] memAddr, jumpAddr, pc;
  logic [7:0]  memRdata, ir, tr;
  logic [3:0]  instruction;

  logic        memReqW, instrValidW;
  logic [11:0] memAddrW, pcW;
  logic [7:0]  memRdataW, irW, trW;
  logic [3:0]  instructionW;
  logic        takeW = 1'b0;
  logic        jumpEnW = 1'b0;
  logic [11:0] jumpAddrW = 12'h000;

  logic [7:0]  mem [0:4095];
  int          waitCycles = 0;
  int          memCnt;
  logic [11:0] latAddr;
  int          cycleCnt = 0;
  int          testsRun = 0;
  int          failures = 0;

  typedef struct packed {
    logic [7:0]  ir;
    logic [7:0]  tr;
    logic [11:0] pc;
  } exp_t;
  exp_t expQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt++;

  fetch_unit #(.ADDR_W(12), .DATA_W(8), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst(rst),
    .mem_req_o(memReq), .mem_addr_o(memAddr), .mem_rdata_i(memRdata), .mem_ack_i(memAck),
    .instr_valid_o(instrValid), .instruction_o(instruction), .ir_o(ir), .tr_o(tr),
    .instr_take_i(instrTake), .jump_en_i(jumpEn), .jump_addr_i(jumpAddr), .pc_o(pc)
  );

  fetch_unit #(.ADDR_W(12), .DATA_W(8), .RESET_PC(12'hFFF)) dutWrap (
    .clk(clk), .rst(rst),
    .mem_req_o(memReqW), .mem_addr_o(memAddrW), .mem_rdata_i(memRdataW), .mem_ack_i(memReqW),
    .instr_valid_o(instrValidW), .instruction_o(instructionW), .ir_o(irW), .tr_o(trW),
    .instr_take_i(takeW), .jump_en_i(jumpEnW), .jump_addr_i(jumpAddrW), .pc_o(pcW)
  );

  assign memRdataW = mem[memAddrW];

  // Memory latches its address on the first request cycle and acks after waitCycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memCnt  <= 0;
      latAddr <= 12'h000;
    end else if (memReq && !memAck) begin
      if (memCnt == 0) latAddr <= memAddr;
      memCnt <= memCnt + 1;
    end else begin
      memCnt <= 0;
    end
  end

  assign memAck   = memReq && (memCnt == waitCycles);
  assign memRdata = (memCnt == 0) ? mem[memAddr] : mem[latAddr];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] addr, input logic [7:0] w0, input logic [7:0] w1);
    logic [11:0] a1;
    exp_t e;
    a1 = addr + 12'd1;
    mem[addr] = w0;
    e.ir = w0;
    if (w0[7:6] == 2'b11) begin
      mem[a1] = w1;
      e.tr = w1;
      e.pc = addr + 12'd2;
    end else begin
      e.tr = 8'h00;
      e.pc = a1;
    end
    expQ.push_back(e);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    instrTake = 1'b0;
    jumpEn = 1'b0;
    jumpAddr = 12'h000;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstValid", {31'd0, instrValid}, 32'd0);
    checkOutput("rstReq", {31'd0, memReq}, 32'd0);
    checkOutput("rstPc", {20'd0, pc}, 32'h000);
    checkOutput("rstIr", {24'd0, ir}, 32'h00);
    checkOutput("rstTr", {24'd0, tr}, 32'h00);
    checkOutput("rstPcWrap", {20'd0, pcW}, 32'hFFF);
    rst = 1'b0;
  endtask

  task automatic expectInstr(input bit take, output int validCycle);
    int budget;
    exp_t e;
    budget = 0;
    validCycle = 0;
    while (!instrValid && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    if (!instrValid) begin
      checkOutput("validTimeout", {31'd0, instrValid}, 32'd1);
      if (expQ.size() > 0) void'(expQ.pop_front());
      return;
    end
    if (expQ.size() == 0) begin
      checkOutput("queueEmpty", 32'd0, 32'd1);
      return;
    end
    e = expQ.pop_front();
    validCycle = cycleCnt;
    checkOutput("ir", {24'd0, ir}, {24'd0, e.ir});
    checkOutput("tr", {24'd0, tr}, {24'd0, e.tr});
    checkOutput("instruction", {28'd0, instruction}, {28'd0, e.ir[7:4]});
    checkOutput("pc", {20'd0, pc}, {20'd0, e.pc});
    if (take) begin
      instrTake = 1'b1;
      @(negedge clk);
      instrTake = 1'b0;
    end
  endtask

  initial begin
    int vc, prevVc, gaps, acks;
    bit started;
    instrTake = 1'b0;
    jumpEn = 1'b0;
    jumpAddr = 12'h000;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'hFFF] = 8'h2B;

    // Single word, zero-wait, no take
    waitCycles = 0;
    applyStimulus(12'h000, 8'h25, 8'h00);
    doReset();
    @(negedge clk);
    checkOutput("latReq", {31'd0, memReq}, 32'd1);
    checkOutput("latValid0", {31'd0, instrValid}, 32'd0);
    checkOutput("latAddr", {20'd0, memAddr}, 32'h000);
    @(negedge clk);
    checkOutput("latValid1", {31'd0, instrValid}, 32'd1);
    expectInstr(1'b0, vc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("holdValid", {31'd0, instrValid}, 32'd1);
      checkOutput("holdIr", {24'd0, ir}, 32'h25);
      checkOutput("holdPc", {20'd0, pc}, 32'h001);
    end
    checkOutput("wrapValid", {31'd0, instrValidW}, 32'd1);
    checkOutput("wrapIr", {24'd0, irW}, 32'h2B);
    checkOutput("wrapPc", {20'd0, pcW}, 32'h000);

    // Two-word instruction, 3-cycle wait
    waitCycles = 3;
    applyStimulus(12'h000, 8'hC3, 8'h7A);
    doReset();
    gaps = 0;
    acks = 0;
    started = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instrValid) break;
      if (memReq) started = 1'b1;
      else if (started) gaps++;
      if (memReq && memAck) acks++;
    end
    checkOutput("twoWordAcks", acks, 32'd2);
    checkOutput("twoWordReqGaps", gaps, 32'd0);
    expectInstr(1'b0, vc);

    // Back-to-back take, zero-wait
    waitCycles = 0;
    applyStimulus(12'h000, 8'h10, 8'h00);
    applyStimulus(12'h001, 8'h25, 8'h00);
    applyStimulus(12'h002, 8'h3F, 8'h00);
    applyStimulus(12'h003, 8'h80, 8'h00);
    mem[4] = 8'h11;
    doReset();
    expectInstr(1'b1, prevVc);
    for (int i = 0; i < 3; i++) begin
      expectInstr(1'b1, vc);
      checkOutput("b2bSpacing", vc - prevVc, 32'd2);
      prevVc = vc;
    end

    // Jump in FETCH1 with an outstanding read
    waitCycles = 2;
    mem[0] = 8'h12;
    applyStimulus(12'h100, 8'h34, 8'h00);
    doReset();
    @(negedge clk);
    jumpEn = 1'b1;
    jumpAddr = 12'h100;
    @(negedge clk);
    jumpEn = 1'b0;
    checkOutput("jmpReqHeld", {31'd0, memReq}, 32'd1);
    checkOutput("jmpAddrFollow", {20'd0, memAddr}, 32'h100);
    @(negedge clk);
    @(negedge clk);
    checkOutput("jmpDiscardIr", {24'd0, ir}, 32'h00);
    checkOutput("jmpRefetchAddr", {20'd0, memAddr}, 32'h100);
    expectInstr(1'b0, vc);

    // Jump and take together in HOLD
    waitCycles = 0;
    applyStimulus(12'hABC, 8'h56, 8'h00);
    instrTake = 1'b1;
    jumpEn = 1'b1;
    jumpAddr = 12'hABC;
    @(negedge clk);
    instrTake = 1'b0;
    jumpEn = 1'b0;
    checkOutput("jmpTakeValid", {31'd0, instrValid}, 32'd0);
    checkOutput("jmpTakeAddr", {20'd0, memAddr}, 32'hABC);
    expectInstr(1'b1, vc);

    // Jump in the same cycle as an ack drops that data
    applyStimulus(12'h200, 8'h44, 8'h00);
    checkOutput("ackJmpAck", {31'd0, memAck}, 32'd1);
    jumpEn = 1'b1;
    jumpAddr = 12'h200;
    @(negedge clk);
    jumpEn = 1'b0;
    checkOutput("ackJmpValid", {31'd0, instrValid}, 32'd0);
    checkOutput("ackJmpAddr", {20'd0, memAddr}, 32'h200);
    checkOutput("ackJmpIr", {24'd0, ir}, 32'h56);
    expectInstr(1'b0, vc);
    checkOutput("queueDrained", expQ.size(), 32'd0);

    // Async reset in the middle of FETCH2
    waitCycles = 3;
    mem[0] = 8'hC1;
    mem[1] = 8'h99;
    doReset();
    acks = 0;
    for (int i = 0; i < 20 && acks == 0; i++) begin
      @(negedge clk);
      if (memReq && memAck) acks++;
    end
    @(negedge clk);
    checkOutput("midF2Ir", {24'd0, ir}, 32'hC1);
    checkOutput("midF2Req", {31'd0, memReq}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncReq", {31'd0, memReq}, 32'd0);
    checkOutput("asyncValid", {31'd0, instrValid}, 32'd0);
    checkOutput("asyncPc", {20'd0, pc}, 32'h000);
    checkOutput("asyncIr", {24'd0, ir}, 32'h00);
    checkOutput("asyncTr", {24'd0, tr}, 32'h00);
    checkOutput("asyncInstruction", {28'd0, instruction}, 32'h0);
    checkOutput("asyncPcWrap", {20'd0, pcW}, 32'hFFF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
